// File: rtl/byte_lane_scheduler_pkg.sv
// Shared constants, FSM state type and helpers for the byte lane scheduler.
package byte_lane_scheduler_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Increment with wrap back to zero at n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return ((v + 1) >= n) ? 0 : (v + 1);
  endfunction

endpackage

// File: rtl/byte_lane_scheduler_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after the pointer wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LANE_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [LANE_W-1:0]  i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [LANE_W-1:0]  o_idx
);

  logic              w_found;
  logic [LANE_W-1:0] w_pos;

  // Scan ptr, ptr+1, ... modulo NUM_REQ and grant the first valid request.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_pos = LANE_W'((32'(i_ptr) + off) % NUM_REQ);
      if (i_en && !w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/byte_lane_scheduler.sv
// Round-robin scheduler feeding one 32-to-8 serializer from NUM_REQ word sources.
module byte_lane_scheduler
  import byte_lane_scheduler_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int LANE_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk_4f,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      pause,
  output logic [BYTE_W-1:0]         data_out,
  output logic                      valid_out,
  output logic                      sof_out,
  output logic [LANE_W-1:0]         lane_id,
  output logic                      busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_byte_cnt;
  logic [LANE_W-1:0]   r_ptr;
  logic [LANE_W-1:0]   r_lane;
  logic [WORD_W-1:0]   r_shift;
  logic [BYTE_W-1:0]   r_data_out;
  logic                r_valid_out;
  logic                r_sof_out;
  logic [LANE_W-1:0]   r_lane_id;

  logic                w_last;
  logic                w_accept_en;
  logic [NUM_REQ-1:0]  w_grant;
  logic [LANE_W-1:0]   w_idx;
  logic                w_hs;
  logic [WORD_W-1:0]   w_word;

  assign w_last      = (r_state == SEND) && (r_byte_cnt == LAST_CNT);
  assign w_accept_en = ((r_state == IDLE) || w_last) && !pause && !reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LANE_W  (LANE_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_accept_en),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // Grant only ever lands on a valid requester, so any grant is a handshake.
  assign w_hs      = |w_grant;
  assign req_ready = w_grant;

  // Select the granted requester's word.
  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_word = req_data[i*WORD_W +: WORD_W];
      end
    end
  end

  // FSM, byte counter, shift register and registered byte outputs.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_state     <= IDLE;
      r_byte_cnt  <= '0;
      r_ptr       <= '0;
      r_lane      <= '0;
      r_shift     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_sof_out   <= 1'b0;
      r_lane_id   <= '0;
    end else begin
      if (r_state == SEND) begin
        r_data_out  <= r_shift[WORD_W-1 -: BYTE_W];
        r_shift     <= r_shift << BYTE_W;
        r_valid_out <= 1'b1;
        r_sof_out   <= (r_byte_cnt == '0);
        r_lane_id   <= r_lane;
        r_byte_cnt  <= r_byte_cnt + 1'b1;
        if (w_last) begin
          r_state <= IDLE;
        end
      end else begin
        r_data_out  <= '0;
        r_valid_out <= 1'b0;
        r_sof_out   <= 1'b0;
        r_lane_id   <= '0;
      end
      // A handshake in the last-byte cycle overrides the shift/count/state
      // updates above, so the next word follows with no bubble.
      if (w_hs) begin
        r_shift    <= w_word;
        r_lane     <= w_idx;
        r_ptr      <= LANE_W'(wrap_inc(32'(w_idx), NUM_REQ));
        r_byte_cnt <= '0;
        r_state    <= SEND;
      end
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign sof_out   = r_sof_out;
  assign lane_id   = r_lane_id;
  assign busy      = (r_state == SEND);

endmodule

// File: doc/byte_lane_scheduler.md
Name: byte_lane_scheduler

Overview:
- Round-robin scheduler that shares one 32-to-8 byte serializer among NUM_REQ 32-bit word sources.
- Sits in front of the byte lane on the clk_4f domain.
- Accepts one word per grant via a valid/ready handshake, then emits it MSB byte first over 4 cycles with valid_out.
- Tags each output byte with its source lane and a start-of-word marker.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LANE_W, $clog2(NUM_REQ), width of lane_id (derived, not overridden)

Ports:
clk_4f  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high
req_valid  input  NUM_REQ  per-requester word valid
req_data  input  NUM_REQ*32  requester i word in bits [32*i+31:32*i]
req_ready  output  NUM_REQ  one-hot grant/accept; handshake when req_valid[i] && req_ready[i]
pause  input  1  blocks new grants; an in-flight word always completes
data_out  output  8  serialized byte
valid_out  output  1  data_out valid
sof_out  output  1  high on the first byte ([31:24]) of each word
lane_id  output  LANE_W  source requester of the current byte
busy  output  1  word in flight (state SEND)

Behaviour:
- Reset is synchronous.
  - Takes effect on the next clk_4f edge with reset high.
  - Clears state to IDLE, byte_cnt=0, rr pointer=0 and the shift register.
  - data_out, valid_out, sof_out, lane_id and busy all go to 0.
  - req_ready is forced to 0 while reset is high.
  - A word in flight mid-reset is discarded; no further bytes of it are emitted.
- States:
  - IDLE: nothing in flight.
  - SEND: byte_cnt 0..3 counts emitted bytes.
- Grant window (accept_en):
  - (IDLE || (SEND && byte_cnt==3)) && !pause && !reset.
- Arbitration (combinational):
  - Search order is rr pointer, pointer+1, ..., wrapping modulo NUM_REQ; the first i with req_valid[i] wins.
  - req_ready is one-hot at the winner when accept_en is high, otherwise all-zero.
  - req_ready is never asserted for a requester whose req_valid is low.
- On handshake at edge t:
  - Capture req_data[i] into a 32-bit shift register and i into the lane register.
  - Set pointer to (i+1) mod NUM_REQ.
  - Go to SEND with byte_cnt=0.
- Output (registered):
  - After edge t+1, data_out holds word[31:24], valid_out=1, sof_out=1, lane_id=i.
  - After t+2, t+3 and t+4 it holds word[23:16], [15:8] and [7:0], with sof_out=0.
  - Latency is 1 cycle from handshake to first byte.
- Back-to-back:
  - A handshake in the byte_cnt==3 cycle starts the next word immediately.
  - No bubble; sustained throughput is 1 word per 4 cycles.
  - Without a new handshake at byte_cnt==3, return to IDLE.
  - In IDLE, data_out=0, valid_out=0, sof_out=0, lane_id=0, busy=0.
- pause:
  - Sampled only in grant windows.
  - Raising pause mid-word does not truncate the word.
  - Pointer is unchanged while paused.
- Requesters must hold req_valid and req_data stable until accepted.
  - The block samples req_data only in the handshake cycle.
  - req_valid dropping before grant is legal; that requester is simply not selected.
- Simultaneous events:
  - reset dominates pause and handshakes.
  - All requests valid gives strict rotation 0,1,2,3,0...
  - Pointer wraps from NUM_REQ-1 to 0.

Decomposition:
- Shared package holds:
  - BYTES_PER_WORD=4
  - WORD_W=32
  - BYTE_W=8
  - state enum {IDLE, SEND}
- One sub-module, rr_arbiter:
  - Inputs: request vector, pointer and enable.
  - Outputs: one-hot grant and encoded index.
- The top holds the FSM, byte counter, shift register and output registers.

Test Plan:
- Single request: reset 2 cycles, then req_valid[0]=1 with data 32'hA1B2C3D4. Required: req_ready[0] pulses 1 cycle; next 4 cycles data_out=A1,B2,C3,D4; valid_out=1; sof_out on A1 only; lane_id=0; then IDLE with outputs 0.
- All four valid, word k = 32'h{k}0{k}1{k}2{k}3. Required: 16 consecutive valid bytes with no gap; lane order 0,1,2,3; each req_ready pulse lands in the byte_cnt==3 cycle of the previous word.
- Pointer wrap: lane 3 served, then only lane 0 valid. Required: lane 0 granted next; then with lanes 0 and 1 both valid, lane 1 wins.
- pause raised during byte 2 of a word while lane 2 waits. Required: the current word completes all 4 bytes; no req_ready while pause=1; lane 2 is granted the cycle pause drops.
- reset asserted after byte 2 of word 32'hDEADBEEF. Required: next cycle valid_out=0, data_out=0, busy=0; bytes BE and EF never appear; after release, lane 0 has priority.
- No requests for 20 cycles. Required: req_ready=0, valid_out=0, data_out=8'h00 throughout.
